// File: rtl/fiveinput_scan_ctrl.sv
// ============================================================================
// Module   : fiveinput_scan_ctrl
// Brief    : Steps the fiveinput block through codes lo..hi, samples F after a
//            settle delay and accumulates a 32-bit truth table plus ones count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fiveinput_scan_ctrl #(
    parameter int SETTLE_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [4:0]  lo,
    input  logic [4:0]  hi,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        E,
    input  logic        F,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] table_out,
    output logic [5:0]  ones_cnt
);

    localparam logic [3:0] c_settle = 4'(SETTLE_CYC);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_code;
    logic [4:0]  r_hi;
    logic [3:0]  r_cnt;
    logic [31:0] r_table;
    logic [5:0]  r_ones;
    logic        r_err;

    logic        w_start_ok;
    logic        w_reject;
    logic        w_sample;
    logic        w_last;

    // abort dominates start in IDLE, and suppresses the range error too
    assign w_start_ok = (r_state == S_IDLE) && start && !abort && (lo <= hi);
    assign w_reject   = (r_state == S_IDLE) && start && !abort && (lo > hi);
    assign w_sample   = (r_state == S_SETTLE) && !abort && (r_cnt == 4'd0);
    assign w_last     = (r_code == r_hi);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_sample && w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code  <= 5'd0;
            r_hi    <= 5'd0;
            r_cnt   <= 4'd0;
            r_table <= 32'd0;
            r_ones  <= 6'd0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_reject;
            if (w_start_ok) begin
                r_hi    <= hi;
                r_code  <= lo;
                r_cnt   <= c_settle;
                r_table <= 32'd0;
                r_ones  <= 6'd0;
            end else if ((r_state == S_SETTLE) && !abort) begin
                if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end else begin
                    r_table[r_code] <= F;
                    r_ones          <= r_ones + {5'd0, F};
                    // the code register parks on hi so hi=31 never wraps
                    if (!w_last) begin
                        r_code <= r_code + 5'd1;
                        r_cnt  <= c_settle;
                    end
                end
            end
        end
    end

    assign {A, B, C, D, E} = (r_state == S_SETTLE) ? r_code : 5'd0;
    assign busy            = (r_state == S_SETTLE);
    assign done            = (r_state == S_DONE);
    assign err             = r_err;
    assign table_out       = r_table;
    assign ones_cnt        = r_ones;

endmodule

`default_nettype wire

// File: tb/tb_fiveinput_scan_ctrl.sv
// ============================================================================
// Module   : tb_fiveinput_scan_ctrl
// Brief    : Directed vector bench; three DUTs with settle times 2, 0 and 3.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fiveinput_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       abort;
    logic [4:0] lo;
    logic [4:0] hi;
    logic [2:0] start_v;
    logic [2:0] f;
    logic [2:0] bsy;
    logic [2:0] dn;
    logic [2:0] er;
    logic [4:0]  ae   [3];
    logic [31:0] tbl  [3];
    logic [5:0]  ones [3];
    logic       e3_d1;
    logic       e3_d2;

    int n_cmp  = 0;
    int n_fail = 0;
    int settle [3] = '{2, 0, 3};

    always #5 clk = ~clk;

    fiveinput_scan_ctrl #(.SETTLE_CYC(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort), .lo(lo), .hi(hi),
        .A(ae[0][4]), .B(ae[0][3]), .C(ae[0][2]), .D(ae[0][1]), .E(ae[0][0]), .F(f[0]),
        .busy(bsy[0]), .done(dn[0]), .err(er[0]), .table_out(tbl[0]), .ones_cnt(ones[0])
    );
    fiveinput_scan_ctrl #(.SETTLE_CYC(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort), .lo(lo), .hi(hi),
        .A(ae[1][4]), .B(ae[1][3]), .C(ae[1][2]), .D(ae[1][1]), .E(ae[1][0]), .F(f[1]),
        .busy(bsy[1]), .done(dn[1]), .err(er[1]), .table_out(tbl[1]), .ones_cnt(ones[1])
    );
    fiveinput_scan_ctrl #(.SETTLE_CYC(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort), .lo(lo), .hi(hi),
        .A(ae[2][4]), .B(ae[2][3]), .C(ae[2][2]), .D(ae[2][1]), .E(ae[2][0]), .F(f[2]),
        .busy(bsy[2]), .done(dn[2]), .err(er[2]), .table_out(tbl[2]), .ones_cnt(ones[2])
    );

    // Models of fiveinput: majority, plain E, and E delayed by two cycles
    assign f[0] = ($countones(ae[0]) >= 3);
    assign f[1] = ae[1][0];
    assign f[2] = e3_d2;

    always @(posedge clk) begin
        e3_d1 <= ae[2][0];
        e3_d2 <= e3_d1;
    end

    typedef struct {
        int          sel;
        logic [4:0]  lo;
        logic [4:0]  hi;
        logic [31:0] tbl;
        logic [5:0]  ones;
        int          nb;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] all_out(input int s);
        return {18'd0, ae[s], bsy[s], dn[s], er[s], tbl[s], ones[s]};
    endfunction

    // Runs one scan; reports busy length, done pulse shape and code sequence
    task automatic run_scan(input int s, input logic [4:0] l, input logic [4:0] h,
                            output int nb, output bit dn_ok, output bit code_ok,
                            output logic [31:0] t, output logic [5:0] o);
        @(negedge clk);
        lo = l; hi = h; start_v[s] = 1'b1;
        @(negedge clk);
        start_v[s] = 1'b0;
        nb = 0;
        code_ok = 1'b1;
        while (bsy[s] && nb < 200) begin
            if (ae[s] != 5'(int'(l) + nb / (settle[s] + 1))) code_ok = 1'b0;
            nb++;
            @(negedge clk);
        end
        dn_ok = dn[s];
        t = tbl[s];
        o = ones[s];
        if (ae[s] != 5'd0) code_ok = 1'b0;
        @(negedge clk);
        dn_ok &= !dn[s] && !bsy[s];
        if (ae[s] != 5'd0) code_ok = 1'b0;
    endtask

    task automatic abort_scan(input int s, input int nth, input logic [31:0] et, input logic [5:0] eo);
        @(negedge clk);
        lo = 5'd0; hi = 5'd31; start_v[s] = 1'b1;
        @(negedge clk);
        start_v[s] = 1'b0;
        for (int i = 1; i < nth; i++) @(negedge clk);
        chk($sformatf("abort%0d busy_at_n", s), 64'(bsy[s]), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk($sformatf("abort%0d idle", s), {62'd0, bsy[s], dn[s]}, 64'd0);
        @(negedge clk);
        chk($sformatf("abort%0d no_done", s), {62'd0, bsy[s], dn[s]}, 64'd0);
        chk($sformatf("abort%0d table", s), 64'(tbl[s]), 64'(et));
        chk($sformatf("abort%0d ones", s), 64'(ones[s]), 64'(eo));
    endtask

    initial begin
        int          nb;
        bit          dn_ok;
        bit          code_ok;
        logic [31:0] t;
        logic [5:0]  o;
        int          guard;

        vecs[0] = '{0, 5'd0,  5'd31, 32'hFEE8_E880, 6'd16, 96};
        vecs[1] = '{1, 5'd4,  5'd6,  32'h0000_0020, 6'd1,  3};
        vecs[2] = '{2, 5'd4,  5'd6,  32'h0000_0020, 6'd1,  12};
        vecs[3] = '{1, 5'd0,  5'd31, 32'hAAAA_AAAA, 6'd16, 32};
        vecs[4] = '{0, 5'd31, 5'd31, 32'h8000_0000, 6'd1,  3};
        vecs[5] = '{0, 5'd5,  5'd9,  32'h0000_0080, 6'd1,  15};

        rst_n = 1'b0; abort = 1'b0; start_v = 3'b000; lo = 5'd0; hi = 5'd0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) chk($sformatf("reset%0d outputs", s), all_out(s), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_scan(vecs[i].sel, vecs[i].lo, vecs[i].hi, nb, dn_ok, code_ok, t, o);
            chk($sformatf("v%0d busy_cycles", i), 64'(nb), 64'(vecs[i].nb));
            chk($sformatf("v%0d done_pulse", i), 64'(dn_ok), 64'd1);
            chk($sformatf("v%0d code_seq", i), 64'(code_ok), 64'd1);
            chk($sformatf("v%0d table", i), 64'(t), 64'(vecs[i].tbl));
            chk($sformatf("v%0d ones", i), 64'(o), 64'(vecs[i].ones));
        end

        // lo > hi rejected: one-cycle err, results from the 5..9 scan kept
        @(negedge clk);
        lo = 5'd9; hi = 5'd8; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("reject err_high", {62'd0, er[0], bsy[0]}, 64'd2);
        @(negedge clk);
        chk("reject err_low", {62'd0, er[0], bsy[0]}, 64'd0);
        chk("reject table_kept", 64'(tbl[0]), 64'h80);

        abort_scan(0, 10, 32'h0, 6'd0);
        abort_scan(1, 10, 32'h0000_00AA, 6'd4);

        // start together with abort in IDLE must not begin a scan
        @(negedge clk);
        lo = 5'd0; hi = 5'd3; start_v[0] = 1'b1; abort = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0; abort = 1'b0;
        chk("start_abort no_scan", {61'd0, bsy[0], dn[0], er[0]}, 64'd0);

        // single code 31 with start held high through done
        @(negedge clk);
        lo = 5'd31; hi = 5'd31; start_v[0] = 1'b1;
        @(negedge clk);
        nb = 0;
        while (bsy[0] && nb < 50) begin
            nb++;
            @(negedge clk);
        end
        chk("single busy_cycles", 64'(nb), 64'd3);
        chk("single done", 64'(dn[0]), 64'd1);
        @(negedge clk);
        chk("held_start ignored", {62'd0, bsy[0], dn[0]}, 64'd0);
        start_v[0] = 1'b0;
        @(negedge clk);
        chk("held_start still_idle", 64'(bsy[0]), 64'd0);
        chk("single table", 64'(tbl[0]), 64'h8000_0000);
        run_scan(0, 5'd5, 5'd9, nb, dn_ok, code_ok, t, o);
        chk("fresh table_cleared", 64'(t), 64'h80);
        chk("fresh ones", 64'(o), 64'd1);

        // asynchronous reset while code 5 is on the bus
        @(negedge clk);
        lo = 5'd0; hi = 5'd31; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        guard = 0;
        while (ae[0] != 5'd5 && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        chk("async code5_reached", 64'(ae[0]), 64'd5);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async reset outputs", all_out(0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset idle", {58'd0, bsy[0], ae[0]}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
